// File: rtl/parking_pkg.sv
// ----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking gate controller. It holds the LCD message
// codes, which double as the FSM state encoding, the keypad codes, the BCD year
// prefix of a well-formed ID, and small decode helpers.
// ----------------------------------------------------------------------------
package parking_pkg;

   // LCD message codes consumed by the LCD message block
   localparam logic [3:0] LCD_ENTER_PARK       = 4'd0;
   localparam logic [3:0] LCD_GRANTED          = 4'd1;
   localparam logic [3:0] LCD_DENIED           = 4'd2;
   localparam logic [3:0] LCD_ENTER_EXIT       = 4'd3;
   localparam logic [3:0] LCD_FULL             = 4'd4;
   localparam logic [3:0] LCD_ADMIN_LOGIN      = 4'd5;
   localparam logic [3:0] LCD_ADMIN_OK         = 4'd6;
   localparam logic [3:0] LCD_ADMIN_DENIED     = 4'd7;
   localparam logic [3:0] LCD_MENU             = 4'd8;
   localparam logic [3:0] LCD_GATE_OPEN        = 4'd9;
   localparam logic [3:0] LCD_RESTRICT_ENTRY   = 4'd10;
   localparam logic [3:0] LCD_RESTRICTED       = 4'd11;
   localparam logic [3:0] LCD_RESTRICT_INVALID = 4'd12;
   localparam logic [3:0] LCD_OFF              = 4'd15;

   // The state encoding equals the message code, so LCD_State is the state register
   typedef enum logic [3:0] {
      ST_ENTER_PARK       = LCD_ENTER_PARK,
      ST_GRANTED          = LCD_GRANTED,
      ST_DENIED           = LCD_DENIED,
      ST_ENTER_EXIT       = LCD_ENTER_EXIT,
      ST_FULL             = LCD_FULL,
      ST_ADMIN_LOGIN      = LCD_ADMIN_LOGIN,
      ST_ADMIN_OK         = LCD_ADMIN_OK,
      ST_ADMIN_DENIED     = LCD_ADMIN_DENIED,
      ST_MENU             = LCD_MENU,
      ST_GATE_OPEN        = LCD_GATE_OPEN,
      ST_RESTRICT_ENTRY   = LCD_RESTRICT_ENTRY,
      ST_RESTRICTED       = LCD_RESTRICTED,
      ST_RESTRICT_INVALID = LCD_RESTRICT_INVALID,
      ST_OFF              = LCD_OFF
   } lcd_state_e;

   // Keypad codes
   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;

   // A well-formed ID starts with the BCD year 2023 in its top four digits
   localparam logic [15:0] YEAR_PREFIX = 16'h2023;
   localparam logic [2:0]  ID_DIGITS   = 3'd7;

   // True for the timed message states that leave on hold expiry
   function automatic logic is_transient(input lcd_state_e s);
      logic r;
      case (s)
         ST_GRANTED, ST_DENIED, ST_ADMIN_OK, ST_ADMIN_DENIED,
         ST_GATE_OPEN, ST_RESTRICTED, ST_RESTRICT_INVALID: r = 1'b1;
         default:                                          r = 1'b0;
      endcase
      return r;
   endfunction

   // True for the states that collect keypad digits
   function automatic logic is_collecting(input lcd_state_e s);
      logic r;
      case (s)
         ST_ENTER_PARK, ST_ENTER_EXIT, ST_ADMIN_LOGIN, ST_RESTRICT_ENTRY: r = 1'b1;
         default:                                                         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/id_entry_buffer.sv
// ----------------------------------------------------------------------------
// id_entry_buffer
// Collects up to seven keypad digits into a BCD ID. New digits enter at the
// least significant digit, and digits after the seventh are dropped.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         synchronous clear (takes priority over keys)
//   en_i          keys are accepted only while high
//   key_valid_i   key strobe, key_code_i key code (0-9 digit, CLEAR empties)
//   digits_o      28-bit BCD buffer, count_o digits held, fmt_ok_o well-formed ID
// ----------------------------------------------------------------------------
module id_entry_buffer
   import parking_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        key_valid_i,
   input  logic [3:0]  key_code_i,
   output logic [27:0] digits_o,
   output logic [2:0]  count_o,
   output logic        fmt_ok_o
);

   logic [27:0] digits_q, digits_d;
   logic [2:0]  count_q,  count_d;

   // Next-state for the digit shift register and its fill count
   always_comb begin
      digits_d = digits_q;
      count_d  = count_q;
      if (clr_i) begin
         digits_d = 28'h0000000;
         count_d  = 3'd0;
      end else if (en_i && key_valid_i && (key_code_i == KEY_CLEAR)) begin
         digits_d = 28'h0000000;
         count_d  = 3'd0;
      end else if (en_i && key_valid_i && (key_code_i <= 4'd9) && (count_q < ID_DIGITS)) begin
         digits_d = {digits_q[23:0], key_code_i};
         count_d  = count_q + 3'd1;
      end else begin
         digits_d = digits_q;
         count_d  = count_q;
      end
   end

   // Buffer registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         digits_q <= 28'h0000000;
         count_q  <= 3'd0;
      end else begin
         digits_q <= digits_d;
         count_q  <= count_d;
      end
   end

   assign digits_o = digits_q;
   assign count_o  = count_q;
   assign fmt_ok_o = (count_q == ID_DIGITS) && (digits_q[27:12] == YEAR_PREFIX);

endmodule

// File: rtl/parking_lcd_sequencer.sv
// ----------------------------------------------------------------------------
// parking_lcd_sequencer
// Parking gate controller FSM. It validates keypad IDs for the entry and exit
// lanes, tracks lot occupancy, keeps a small restricted-ID table managed from an
// admin menu, and drives the LCD message code, the granted ID and the gate.
// Ports:
//   iCLK, iRST   clock, asynchronous active-high reset
//   key_valid    key strobe, key_code 0-9 / 4'hA ENTER / 4'hB CLEAR
//   mode_exit    lane select (1 = exit), sampled in idle states
//   admin_req    admin login strobe, park_en 0 forces OFF
//   LCD_State    message code (equals the state), ID granted ID
//   gate_open    gate actuator, occupancy occupied spaces
// ----------------------------------------------------------------------------
module parking_lcd_sequencer
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY       = 8,
   parameter int unsigned HOLD_CYCLES    = 150_000_000,
   parameter int unsigned RESTRICT_DEPTH = 4,
   parameter logic [27:0] ADMIN_ID       = 28'h2023000
)(
   input  logic                            iCLK,
   input  logic                            iRST,
   input  logic                            key_valid,
   input  logic [3:0]                      key_code,
   input  logic                            mode_exit,
   input  logic                            admin_req,
   input  logic                            park_en,
   output logic [3:0]                      LCD_State,
   output logic [27:0]                     ID,
   output logic                            gate_open,
   output logic [$clog2(CAPACITY+1)-1:0]   occupancy
);

   localparam int unsigned OW = $clog2(CAPACITY + 1);
   localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned PW = (RESTRICT_DEPTH > 1) ? $clog2(RESTRICT_DEPTH) : 1;
   localparam logic [OW-1:0] OCC_CAP   = OW'(CAPACITY);
   localparam logic [OW-1:0] OCC_ONE   = OW'(1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

   lcd_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [OW-1:0] occ_q,   occ_d;
   logic [27:0]   id_q,    id_d;
   logic          gate_q,  gate_d;

   logic [27:0]         tbl_id_q [RESTRICT_DEPTH];
   logic [RESTRICT_DEPTH-1:0] tbl_vld_q;
   logic [PW-1:0]       wr_ptr_q;
   logic                wr_en_s;
   logic                hit_s;

   logic [27:0] buf_s;
   logic [2:0]  cnt_s;
   logic        fmt_ok_s;
   logic        buf_clr_s;
   lcd_state_e  idle_s;
   logic        enter_s, clear_s, expire_s;

   assign enter_s  = key_valid && (key_code == KEY_ENTER);
   assign clear_s  = key_valid && (key_code == KEY_CLEAR);
   assign expire_s = is_transient(state_q) && (timer_q == HOLD_LAST);
   // The idle state the lane and fill level call for right now
   assign idle_s   = mode_exit ? ST_ENTER_EXIT :
                     ((occ_q == OCC_CAP) ? ST_FULL : ST_ENTER_PARK);
   // Every state change, and the OFF override, starts the next entry empty
   assign buf_clr_s = (state_d != state_q) || !park_en;

   id_entry_buffer u_buf (
      .clk_i       (iCLK),
      .rst_i       (iRST),
      .clr_i       (buf_clr_s),
      .en_i        (is_collecting(state_q)),
      .key_valid_i (key_valid),
      .key_code_i  (key_code),
      .digits_o    (buf_s),
      .count_o     (cnt_s),
      .fmt_ok_o    (fmt_ok_s)
   );

   // Restricted-table lookup of the current buffer contents
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < RESTRICT_DEPTH; i++) begin
         if (tbl_vld_q[i] && (tbl_id_q[i] == buf_s)) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // FSM next-state, occupancy, granted ID and table write decision
   always_comb begin
      state_d = state_q;
      occ_d   = occ_q;
      id_d    = id_q;
      wr_en_s = 1'b0;
      if (!park_en) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: state_d = idle_s;
            ST_ENTER_PARK: begin
               if (admin_req) begin
                  state_d = ST_ADMIN_LOGIN;
               end else if (idle_s != ST_ENTER_PARK) begin
                  state_d = idle_s;
               end else if (enter_s) begin
                  if (fmt_ok_s && !hit_s) begin
                     state_d = ST_GRANTED;
                     id_d    = buf_s;
                     occ_d   = (occ_q < OCC_CAP) ? (occ_q + OCC_ONE) : occ_q;
                  end else begin
                     state_d = ST_DENIED;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_ENTER_EXIT: begin
               if (admin_req) begin
                  state_d = ST_ADMIN_LOGIN;
               end else if (idle_s != ST_ENTER_EXIT) begin
                  state_d = idle_s;
               end else if (enter_s) begin
                  if (fmt_ok_s && (occ_q != {OW{1'b0}})) begin
                     state_d = ST_GRANTED;
                     id_d    = buf_s;
                     occ_d   = occ_q - OCC_ONE;
                  end else begin
                     state_d = ST_DENIED;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_FULL: begin
               if (admin_req) begin
                  state_d = ST_ADMIN_LOGIN;
               end else if ((occ_q < OCC_CAP) || mode_exit) begin
                  state_d = ST_ENTER_PARK;
               end else begin
                  state_d = state_q;
               end
            end
            ST_ADMIN_LOGIN: begin
               if (clear_s) begin
                  state_d = idle_s;
               end else if (enter_s) begin
                  state_d = ((buf_s == ADMIN_ID) && (cnt_s == ID_DIGITS)) ? ST_ADMIN_OK
                                                                          : ST_ADMIN_DENIED;
               end else begin
                  state_d = state_q;
               end
            end
            ST_MENU: begin
               if (key_valid && (key_code == 4'd1)) begin
                  state_d = ST_GATE_OPEN;
               end else if (key_valid && (key_code == 4'd2)) begin
                  state_d = ST_RESTRICT_ENTRY;
               end else if (clear_s) begin
                  state_d = idle_s;
               end else begin
                  state_d = state_q;
               end
            end
            ST_RESTRICT_ENTRY: begin
               if (clear_s) begin
                  state_d = ST_MENU;
               end else if (enter_s) begin
                  if (fmt_ok_s) begin
                     state_d = ST_RESTRICTED;
                     wr_en_s = !hit_s;   // an ID already listed is not stored twice
                  end else begin
                     state_d = ST_RESTRICT_INVALID;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            // Keys are not decoded in timed states, so a key on the expiry cycle is lost
            ST_GRANTED, ST_DENIED, ST_ADMIN_DENIED, ST_GATE_OPEN: begin
               if (expire_s) begin
                  state_d = idle_s;
               end else begin
                  state_d = state_q;
               end
            end
            ST_ADMIN_OK, ST_RESTRICTED, ST_RESTRICT_INVALID: begin
               if (expire_s) begin
                  state_d = ST_MENU;
               end else begin
                  state_d = state_q;
               end
            end
            default: state_d = ST_ENTER_PARK;
         endcase
      end
   end

   // Hold timer restarts on every state change; gate follows the next state
   always_comb begin
      if (state_d != state_q) begin
         timer_d = {TW{1'b0}};
      end else if (is_transient(state_q)) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = {TW{1'b0}};
      end
      gate_d = (state_d == ST_GRANTED) || (state_d == ST_GATE_OPEN);
   end

   // State, timer and output registers
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= ST_ENTER_PARK;
         timer_q <= {TW{1'b0}};
         occ_q   <= {OW{1'b0}};
         id_q    <= 28'h0000000;
         gate_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         occ_q   <= occ_d;
         id_q    <= id_d;
         gate_q  <= gate_d;
      end
   end

   // Restricted-ID table, overwritten round-robin once full
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int i = 0; i < RESTRICT_DEPTH; i++) begin
            tbl_id_q[i] <= 28'h0000000;
         end
         tbl_vld_q <= {RESTRICT_DEPTH{1'b0}};
         wr_ptr_q  <= {PW{1'b0}};
      end else if (wr_en_s) begin
         tbl_id_q[wr_ptr_q]  <= buf_s;
         tbl_vld_q[wr_ptr_q] <= 1'b1;
         wr_ptr_q            <= wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_q <= wr_ptr_q;
      end
   end

   assign LCD_State = state_q;
   assign ID        = id_q;
   assign gate_open = gate_q;
   assign occupancy = occ_q;

endmodule
